// File: rtl/rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_driver
// Purpose  : Three-channel RGB PWM driver with period-aligned shadow duties
//            and cross-fade between the active and previous colour channel.
//            Optional macro RGB_PWM_GAMMA_EN: squared (gamma) duty correction.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pwm_driver #(
    parameter int PWM_INTERVAL   = 1200,
    parameter bit LED_ACTIVE_LOW = 1'b1,
    parameter int DW             = $clog2(PWM_INTERVAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pwm_value,
    input  logic [1:0]    state,
    output logic          red,
    output logic          green,
    output logic          blue,
    output logic          period_start
);

    localparam logic [DW-1:0] c_pwm     = DW'(PWM_INTERVAL);
    localparam logic [DW-1:0] c_cnt_max = DW'(PWM_INTERVAL - 1);

    logic [DW-1:0]        r_cnt;
    logic [DW-1:0]        w_cnt_next;
    logic                 r_rst_d;
    logic                 r_period_start;
    logic [DW-1:0]        w_sat;
    logic [DW-1:0]        w_din_next;
    logic [DW-1:0]        r_d_in;
    logic [1:0]           r_st_in;
    logic [2:0][DW-1:0]   w_duty;
    logic [2:0][DW-1:0]   r_shadow;
    logic [2:0]           r_on;

    assign w_sat = (pwm_value >= c_pwm) ? c_pwm : pwm_value;

`ifdef RGB_PWM_GAMMA_EN
    logic [2*DW-1:0] w_sq;
    assign w_sq       = {{DW{1'b0}}, w_sat} * {{DW{1'b0}}, w_sat};
    assign w_din_next = DW'(w_sq / (2*DW)'(PWM_INTERVAL));
`else
    assign w_din_next = w_sat;
`endif

    // The first cycle after reset holds the counter at 0 so it carries the period_start pulse.
    always_comb begin
        w_cnt_next = r_cnt + DW'(1);
        if (r_rst_d || (r_cnt == c_cnt_max)) begin
            w_cnt_next = '0;
        end
    end

    // Active channel k gets d_in, channel (k+2) mod 3 gets the complement.
    always_comb begin
        w_duty = '0;
        case (r_st_in)
            2'd0: begin
                w_duty[0] = r_d_in;
                w_duty[2] = c_pwm - r_d_in;
            end
            2'd1: begin
                w_duty[1] = r_d_in;
                w_duty[0] = c_pwm - r_d_in;
            end
            2'd2: begin
                w_duty[2] = r_d_in;
                w_duty[1] = c_pwm - r_d_in;
            end
            default: w_duty = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_rst_d        <= 1'b1;
            r_period_start <= 1'b0;
            r_d_in         <= '0;
            r_st_in        <= '0;
            r_shadow       <= '0;
            r_on           <= '0;
        end else begin
            r_rst_d        <= 1'b0;
            r_cnt          <= w_cnt_next;
            r_period_start <= (w_cnt_next == '0);
            r_d_in         <= w_din_next;
            r_st_in        <= state;
            if (r_cnt == c_cnt_max) begin
                r_shadow <= w_duty;
            end
            r_on <= {(r_cnt < r_shadow[2]), (r_cnt < r_shadow[1]), (r_cnt < r_shadow[0])};
        end
    end

    assign red          = r_on[0] ^ LED_ACTIVE_LOW;
    assign green        = r_on[1] ^ LED_ACTIVE_LOW;
    assign blue         = r_on[2] ^ LED_ACTIVE_LOW;
    assign period_start = r_period_start;

endmodule
`default_nettype wire
